// File: rtl/fb_write_scheduler_if.sv
// Framebuffer write scheduler bus: two byte-write requesters, clear control, write port.
// FB_WRITE_STATS_EN adds per-port grant counters.
interface fb_write_scheduler_if #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 8
);
  logic                 req0_valid;
  logic                 req0_ready;
  logic [ADDR_BITS-1:0] req0_addr;
  logic [DATA_BITS-1:0] req0_data;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [ADDR_BITS-1:0] req1_addr;
  logic [DATA_BITS-1:0] req1_data;
  logic                 clear_start;
  logic                 clear_busy;
  logic                 clear_done;
  logic [ADDR_BITS-1:0] fb_addr;
  logic [DATA_BITS-1:0] fb_data;
  logic                 fb_wr;
`ifdef FB_WRITE_STATS_EN
  logic [15:0]          stat0_count;
  logic [15:0]          stat1_count;
`endif

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output clear_start,
    input  req0_ready, req1_ready,
    input  clear_busy, clear_done,
    input  fb_addr, fb_data, fb_wr
`ifdef FB_WRITE_STATS_EN
    , input stat0_count, stat1_count
`endif
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  clear_start,
    output req0_ready, req1_ready,
    output clear_busy, clear_done,
    output fb_addr, fb_data, fb_wr
`ifdef FB_WRITE_STATS_EN
    , output stat0_count, stat1_count
`endif
  );
endinterface

// File: rtl/fb_write_scheduler.sv
// Round-robin framebuffer write arbiter with a full-address clear sweep.
// Optional FB_WRITE_STATS_EN: saturating per-port grant counters.
module fb_write_scheduler #(
  parameter int ADDR_BITS   = 12,
  parameter int DATA_BITS   = 8,
  parameter int CLEAR_VALUE = 0
) (
  input  logic                clk,
  input  logic                reset,
  fb_write_scheduler_if.slave bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_BITS-1:0] r_cnt;
  logic [ADDR_BITS-1:0] w_cnt_nxt;
  logic                 r_last_grant;
  logic                 w_g0;
  logic                 w_g1;
  logic                 w_clr_issue;
  logic                 w_clr_last;
  logic                 r_fb_wr;
  logic [ADDR_BITS-1:0] r_fb_addr;
  logic [DATA_BITS-1:0] r_fb_data;
  logic                 r_clear_done;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_g0        = 1'b0;
    w_g1        = 1'b0;
    w_clr_issue = 1'b0;
    w_clr_last  = 1'b0;
    case (r_state)
      IDLE: begin
        // r_last_grant=1 means port 1 won last, so port 0 wins a tie
        if (!reset) begin
          if (bus.req0_valid && bus.req1_valid) begin
            w_g0 = r_last_grant;
            w_g1 = !r_last_grant;
          end else begin
            w_g0 = bus.req0_valid;
            w_g1 = bus.req1_valid;
          end
        end
        if (bus.clear_start) w_state_nxt = CLEAR;
      end
      CLEAR: begin
        w_clr_issue = 1'b1;
        w_cnt_nxt   = r_cnt + 1'b1;
        if (&r_cnt) begin
          w_clr_last  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_fb_wr      <= 1'b0;
      r_fb_addr    <= '0;
      r_fb_data    <= '0;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_fb_wr      <= w_g0 | w_g1 | w_clr_issue;
      r_clear_done <= w_clr_last;
      if (w_g0 | w_g1) r_last_grant <= w_g1;
      if (w_clr_issue) begin
        r_fb_addr <= r_cnt;
        r_fb_data <= DATA_BITS'(CLEAR_VALUE);
      end else if (w_g0) begin
        r_fb_addr <= bus.req0_addr;
        r_fb_data <= bus.req0_data;
      end else if (w_g1) begin
        r_fb_addr <= bus.req1_addr;
        r_fb_data <= bus.req1_data;
      end
    end
  end

  assign bus.req0_ready = w_g0;
  assign bus.req1_ready = w_g1;
  assign bus.clear_busy = (r_state == CLEAR);
  assign bus.clear_done = r_clear_done;
  assign bus.fb_wr      = r_fb_wr;
  assign bus.fb_addr    = r_fb_addr;
  assign bus.fb_data    = r_fb_data;

`ifdef FB_WRITE_STATS_EN
  logic [15:0] r_stat0;
  logic [15:0] r_stat1;
  logic        w_clr_entry;

  assign w_clr_entry = (r_state == IDLE) && (w_state_nxt == CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat0 <= '0;
      r_stat1 <= '0;
    end else if (w_clr_entry) begin
      r_stat0 <= '0;
      r_stat1 <= '0;
    end else begin
      if (w_g0 && r_stat0 != 16'hFFFF) r_stat0 <= r_stat0 + 16'd1;
      if (w_g1 && r_stat1 != 16'hFFFF) r_stat1 <= r_stat1 + 16'd1;
    end
  end

  assign bus.stat0_count = r_stat0;
  assign bus.stat1_count = r_stat1;
`endif

endmodule
